// File: rtl/muldiv_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_issue_ctrl
// Purpose  : hi/lo issue controller: launches mul/div units, counts latency,
//            stalls ID on hi/lo hazards and drives hi/lo/regfile writeback.
//            Optional feature macro: DIVZERO_TRAP_EN (divide-by-zero trap).
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_issue_ctrl #(
    parameter  int MUL_LAT = 3,
    parameter  int DIV_LAT = 32,
    localparam int CNT_W   = $clog2(((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT) + 1)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [31:0] id_instruction,
    input  logic        flush,
    input  logic        div_by_zero,
    output logic        mul_start,
    output logic        div_start,
    output logic        mul_sign,
    output logic        div_sign,
    output logic        hi_wena,
    output logic        lo_wena,
    output logic [1:0]  hi_mux_sel,
    output logic [1:0]  lo_mux_sel,
    output logic        rf_wb,
    output logic [4:0]  rf_wb_addr,
    output logic        stall_id,
    output logic        busy,
    output logic        exception,
    output logic [4:0]  cause
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_BUSY = 2'd1,
        S_DIV_BUSY = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] c_MUL_CNT   = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] c_DIV_CNT   = CNT_W'(DIV_LAT - 1);
    localparam logic [1:0]       c_SEL_DIV   = 2'b00;
    localparam logic [1:0]       c_SEL_MUL   = 2'b01;
    localparam logic [1:0]       c_SEL_RS    = 2'b10;

    // ------------------------------------------------------------------ decode
    logic [5:0] w_op;
    logic [5:0] w_func;
    logic       w_special;
    logic       w_is_mul, w_is_multu, w_is_div, w_is_divu;
    logic       w_is_mthi, w_is_mtlo, w_is_mfhi, w_is_mflo;
    logic       w_is_mulop, w_is_divop, w_hazard;

    assign w_op       = id_instruction[31:26];
    assign w_func     = id_instruction[5:0];
    assign w_special  = (w_op == 6'b000000);
    assign w_is_mul   = (w_op == 6'b011100) && (w_func == 6'b000010);
    assign w_is_multu = w_special && (w_func == 6'b011001);
    assign w_is_div   = w_special && (w_func == 6'b011010);
    assign w_is_divu  = w_special && (w_func == 6'b011011);
    assign w_is_mthi  = w_special && (w_func == 6'b010001);
    assign w_is_mtlo  = w_special && (w_func == 6'b010011);
    assign w_is_mfhi  = w_special && (w_func == 6'b010000);
    assign w_is_mflo  = w_special && (w_func == 6'b010010);
    assign w_is_mulop = w_is_mul | w_is_multu;
    assign w_is_divop = w_is_div | w_is_divu;
    assign w_hazard   = w_is_mulop | w_is_divop | w_is_mthi | w_is_mtlo |
                        w_is_mfhi | w_is_mflo;

    logic w_unused_instr;
    assign w_unused_instr = ^{id_instruction[25:16], id_instruction[10:6]};

    // ------------------------------------------------------------------- state
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mul_start_q, mul_start_d;
    logic             div_start_q, div_start_d;
    logic             mul_sign_q, mul_sign_d;
    logic             div_sign_q, div_sign_d;
    logic [4:0]       rd_q, rd_d;

    logic w_idle, w_accept, w_trap, w_launch, w_start_pending, w_wb;
    logic w_mthi_wr, w_mtlo_wr;

    assign w_idle          = (state_q == S_IDLE);
    assign w_accept        = w_idle && id_valid && (w_is_mulop | w_is_divop) && !flush;
    assign w_launch        = w_accept && !w_trap;
    // The counter holds during the start-pulse cycle so the result lands
    // LAT cycles after the pulse, i.e. LAT+1 cycles after accept.
    assign w_start_pending = mul_start_q | div_start_q;
    assign w_wb            = !w_idle && !w_start_pending && (cnt_q == '0) && !flush;
    assign w_mthi_wr       = w_idle && id_valid && !flush && w_is_mthi;
    assign w_mtlo_wr       = w_idle && id_valid && !flush && w_is_mtlo;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mul_start_d = 1'b0;
        div_start_d = 1'b0;
        mul_sign_d  = mul_sign_q;
        div_sign_d  = div_sign_q;
        rd_d        = rd_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_launch) begin
                        rd_d = w_is_mul ? id_instruction[15:11] : 5'd0;
                        if (w_is_mulop) begin
                            state_d     = S_MUL_BUSY;
                            cnt_d       = c_MUL_CNT;
                            mul_start_d = 1'b1;
                            mul_sign_d  = w_is_mul;
                            div_sign_d  = 1'b0;
                        end else begin
                            state_d     = S_DIV_BUSY;
                            cnt_d       = c_DIV_CNT;
                            div_start_d = 1'b1;
                            div_sign_d  = w_is_div;
                            mul_sign_d  = 1'b0;
                        end
                    end
                end
                S_MUL_BUSY, S_DIV_BUSY: begin
                    if (w_wb) begin
                        state_d = S_IDLE;
                    end else if (!w_start_pending) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mul_start_q <= 1'b0;
            div_start_q <= 1'b0;
            mul_sign_q  <= 1'b0;
            div_sign_q  <= 1'b0;
            rd_q        <= 5'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mul_start_q <= mul_start_d;
            div_start_q <= div_start_d;
            mul_sign_q  <= mul_sign_d;
            div_sign_q  <= div_sign_d;
            rd_q        <= rd_d;
        end
    end

    // ------------------------------------------------------- divide-by-zero trap
`ifdef DIVZERO_TRAP_EN
    localparam logic [4:0] c_CAUSE_DIVZ = 5'b01100;

    logic       exception_q, exception_d;
    logic [4:0] cause_q, cause_d;

    assign w_trap      = w_accept && w_is_divop && div_by_zero;
    assign exception_d = w_trap;
    assign cause_d     = w_trap ? c_CAUSE_DIVZ : 5'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exception_q <= 1'b0;
            cause_q     <= 5'd0;
        end else begin
            exception_q <= exception_d;
            cause_q     <= cause_d;
        end
    end

    assign exception = exception_q;
    assign cause     = cause_q;
`else
    logic w_unused_divz;
    assign w_unused_divz = div_by_zero;
    assign w_trap        = 1'b0;
    assign exception     = 1'b0;
    assign cause         = 5'd0;
`endif

    // ------------------------------------------------------------------ outputs
    always_comb begin
        hi_wena    = 1'b0;
        lo_wena    = 1'b0;
        hi_mux_sel = c_SEL_DIV;
        lo_mux_sel = c_SEL_DIV;
        rf_wb      = 1'b0;
        if (w_wb) begin
            hi_wena = 1'b1;
            lo_wena = 1'b1;
            if (state_q == S_MUL_BUSY) begin
                hi_mux_sel = c_SEL_MUL;
                lo_mux_sel = c_SEL_MUL;
                // mul_sign_q is set only for the three-operand mul, the one
                // op that also writes the register file.
                rf_wb      = mul_sign_q;
            end
        end else begin
            if (w_mthi_wr) begin
                hi_wena    = 1'b1;
                hi_mux_sel = c_SEL_RS;
            end
            if (w_mtlo_wr) begin
                lo_wena    = 1'b1;
                lo_mux_sel = c_SEL_RS;
            end
        end
    end

    assign mul_start  = mul_start_q;
    assign div_start  = div_start_q;
    assign mul_sign   = mul_sign_q;
    assign div_sign   = div_sign_q;
    assign rf_wb_addr = rd_q;
    assign busy       = !w_idle;
    assign stall_id   = id_valid && w_hazard && !w_idle;

endmodule
`default_nettype wire
